// File: rtl/wb_commit.sv
// wb_commit: dual-issue writeback commit stage. It drives both register-file write
// ports and a one-instruction-per-cycle debug commit trace. The trace is enabled by DEBUG_TRACE_EN.
module wb_commit (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic        v1_i,
   input  logic        v2_i,
   input  logic [31:0] pc1_i,
   input  logic [31:0] pc2_i,
   input  logic        we1_i,
   input  logic        we2_i,
   input  logic [4:0]  waddr1_i,
   input  logic [4:0]  waddr2_i,
   input  logic [31:0] wdata1_i,
   input  logic [31:0] wdata2_i,
   output logic        we_o1,
   output logic        we_o2,
   output logic [4:0]  waddr_o1,
   output logic [4:0]  waddr_o2,
   output logic [31:0] wdata_o1,
   output logic [31:0] wdata_o2,
   output logic [31:0] debug_wb_pc,
   output logic [3:0]  debug_wb_rf_wen,
   output logic [4:0]  debug_wb_rf_wnum,
   output logic [31:0] debug_wb_rf_wdata
);

`ifdef DEBUG_TRACE_EN
   localparam logic TRACE_EN = 1'b1;
`else
   localparam logic TRACE_EN = 1'b0;
`endif

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BEAT1 = 2'd1, ST_BEAT2 = 2'd2} state_t;

   state_t      state_q, state_d;
   logic        accept_s, eff1_s, eff2_s;
   logic        pend2_q, pend2_d;
   logic [31:0] h_pc_q, h_pc_d, h_wdata_q, h_wdata_d;
   logic [4:0]  h_wnum_q, h_wnum_d;
   logic        h_wen_q, h_wen_d;
   logic        we1_q, we1_d, we2_q, we2_d;
   logic [4:0]  waddr1_q, waddr1_d, waddr2_q, waddr2_d;
   logic [31:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;
   logic [31:0] tr_pc_q, tr_pc_d, tr_wdata_q, tr_wdata_d;
   logic [4:0]  tr_wnum_q, tr_wnum_d;
   logic        tr_wen_q, tr_wen_d;

   assign eff1_s = v1_i && we1_i && (waddr1_i != 5'd0);
   assign eff2_s = v2_i && we2_i && (waddr2_i != 5'd0);

   // A pending slot-2 trace beat stalls the pair behind it.
`ifdef DEBUG_TRACE_EN
   assign ready_o = !((state_q == ST_BEAT1) && pend2_q);
`else
   assign ready_o = !rst;
`endif
   assign accept_s = valid_i && ready_o;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection
   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_BEAT1: begin
            if (pend2_q)       state_d = ST_BEAT2;
            else if (accept_s) state_d = ST_BEAT1;
            else               state_d = ST_IDLE;
         end
         ST_IDLE, ST_BEAT2: begin
            if (accept_s) state_d = ST_BEAT1;
            else          state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and holding-register next values, keyed on the state being entered
   always_comb begin
      pend2_d    = 1'b0;
      h_pc_d     = h_pc_q;
      h_wnum_d   = h_wnum_q;
      h_wdata_d  = h_wdata_q;
      h_wen_d    = h_wen_q;
      we1_d      = 1'b0;
      we2_d      = 1'b0;
      waddr1_d   = waddr1_q;
      waddr2_d   = waddr2_q;
      wdata1_d   = wdata1_q;
      wdata2_d   = wdata2_q;
      tr_pc_d    = 32'd0;
      tr_wen_d   = 1'b0;
      tr_wnum_d  = tr_wnum_q;
      tr_wdata_d = tr_wdata_q;
      case (state_d)
         ST_BEAT1: begin
            // Younger slot wins a same-address pair; trace still reports both.
            we1_d     = eff1_s && !(eff2_s && (waddr1_i == waddr2_i));
            we2_d     = eff2_s;
            waddr1_d  = waddr1_i;
            waddr2_d  = waddr2_i;
            wdata1_d  = wdata1_i;
            wdata2_d  = wdata2_i;
            pend2_d   = TRACE_EN && v1_i && v2_i;
            h_pc_d    = pc2_i;
            h_wnum_d  = waddr2_i;
            h_wdata_d = wdata2_i;
            h_wen_d   = eff2_s;
            if (v1_i) begin
               tr_pc_d    = pc1_i;
               tr_wen_d   = eff1_s;
               tr_wnum_d  = waddr1_i;
               tr_wdata_d = wdata1_i;
            end else if (v2_i) begin
               tr_pc_d    = pc2_i;
               tr_wen_d   = eff2_s;
               tr_wnum_d  = waddr2_i;
               tr_wdata_d = wdata2_i;
            end else begin
               tr_pc_d  = 32'd0;
               tr_wen_d = 1'b0;
            end
         end
         ST_BEAT2: begin
            tr_pc_d    = h_pc_q;
            tr_wen_d   = h_wen_q;
            tr_wnum_d  = h_wnum_q;
            tr_wdata_d = h_wdata_q;
         end
         default: begin
            tr_pc_d  = 32'd0;
            tr_wen_d = 1'b0;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pend2_q    <= 1'b0;
         h_pc_q     <= 32'd0;
         h_wnum_q   <= 5'd0;
         h_wdata_q  <= 32'd0;
         h_wen_q    <= 1'b0;
         we1_q      <= 1'b0;
         we2_q      <= 1'b0;
         waddr1_q   <= 5'd0;
         waddr2_q   <= 5'd0;
         wdata1_q   <= 32'd0;
         wdata2_q   <= 32'd0;
         tr_pc_q    <= 32'd0;
         tr_wen_q   <= 1'b0;
         tr_wnum_q  <= 5'd0;
         tr_wdata_q <= 32'd0;
      end else begin
         pend2_q    <= pend2_d;
         h_pc_q     <= h_pc_d;
         h_wnum_q   <= h_wnum_d;
         h_wdata_q  <= h_wdata_d;
         h_wen_q    <= h_wen_d;
         we1_q      <= we1_d;
         we2_q      <= we2_d;
         waddr1_q   <= waddr1_d;
         waddr2_q   <= waddr2_d;
         wdata1_q   <= wdata1_d;
         wdata2_q   <= wdata2_d;
         tr_pc_q    <= tr_pc_d;
         tr_wen_q   <= tr_wen_d;
         tr_wnum_q  <= tr_wnum_d;
         tr_wdata_q <= tr_wdata_d;
      end
   end

   assign we_o1             = we1_q;
   assign we_o2             = we2_q;
   assign waddr_o1          = waddr1_q;
   assign waddr_o2          = waddr2_q;
   assign wdata_o1          = wdata1_q;
   assign wdata_o2          = wdata2_q;
   assign debug_wb_pc       = tr_pc_q & {32{TRACE_EN}};
   assign debug_wb_rf_wen   = {4{tr_wen_q & TRACE_EN}};
   assign debug_wb_rf_wnum  = tr_wnum_q & {5{TRACE_EN}};
   assign debug_wb_rf_wdata = tr_wdata_q & {32{TRACE_EN}};

endmodule

// File: tb/tb_wb_commit.sv
// Directed self-checking bench for wb_commit; trace expectations follow DEBUG_TRACE_EN.
module tb_wb_commit;

`ifdef DEBUG_TRACE_EN
   localparam bit TRACE = 1'b1;
`else
   localparam bit TRACE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, valid_i, ready_o, v1_i, v2_i, we1_i, we2_i;
   logic [31:0] pc1_i, pc2_i, wdata1_i, wdata2_i;
   logic [4:0]  waddr1_i, waddr2_i;
   logic        we_o1, we_o2;
   logic [4:0]  waddr_o1, waddr_o2, debug_wb_rf_wnum;
   logic [31:0] wdata_o1, wdata_o2, debug_wb_pc, debug_wb_rf_wdata;
   logic [3:0]  debug_wb_rf_wen;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   wb_commit dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
      .v1_i(v1_i), .v2_i(v2_i), .pc1_i(pc1_i), .pc2_i(pc2_i),
      .we1_i(we1_i), .we2_i(we2_i), .waddr1_i(waddr1_i), .waddr2_i(waddr2_i),
      .wdata1_i(wdata1_i), .wdata2_i(wdata2_i),
      .we_o1(we_o1), .we_o2(we_o2), .waddr_o1(waddr_o1), .waddr_o2(waddr_o2),
      .wdata_o1(wdata_o1), .wdata_o2(wdata_o2),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic s1, input logic s2,
                        input logic [31:0] p1, input logic [31:0] p2,
                        input logic w1, input logic w2, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] d1, input logic [31:0] d2);
      valid_i = v; v1_i = s1; v2_i = s2; pc1_i = p1; pc2_i = p2;
      we1_i = w1; we2_i = w2; waddr1_i = a1; waddr2_i = a2; wdata1_i = d1; wdata2_i = d2;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      total_cnt++; if (we_o1 !== 1'b0 || we_o2 !== 1'b0) $display("FAIL rst_we got %b%b exp 00", we_o1, we_o2); else pass_cnt++;
      total_cnt++; if (waddr_o1 !== 5'd0 || wdata_o2 !== 32'd0) $display("FAIL rst_data got %h %h exp 0 0", waddr_o1, wdata_o2); else pass_cnt++;
      total_cnt++; if (debug_wb_pc !== 32'd0 || debug_wb_rf_wen !== 4'h0) $display("FAIL rst_trace got %h %h exp 0 0", debug_wb_pc, debug_wb_rf_wen); else pass_cnt++;
      rst = 1'b0; #1;
      total_cnt++; if (ready_o !== 1'b1) $display("FAIL rst_ready got %b exp 1", ready_o); else pass_cnt++;
      drive(1'b1, 1'b1, 1'b1, 32'hbfc00000, 32'hbfc00004, 1'b1, 1'b1, 5'd3, 5'd4, 32'h11, 32'h22);
      @(negedge clk);
      total_cnt++; if (we_o1 !== 1'b1) $display("FAIL rst_pre_we got %b exp 1", we_o1); else pass_cnt++;
      rst = 1'b1; valid_i = 1'b0;
      @(negedge clk);
      total_cnt++; if (we_o1 !== 1'b0 || we_o2 !== 1'b0) $display("FAIL rst_mid_we got %b%b exp 00", we_o1, we_o2); else pass_cnt++;
      total_cnt++; if (debug_wb_rf_wen !== 4'h0) $display("FAIL rst_mid_wen got %h exp 0", debug_wb_rf_wen); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0; #1;
      total_cnt++; if (ready_o !== 1'b1) $display("FAIL rst_mid_ready got %b exp 1", ready_o); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (we_o2 !== 1'b0 || debug_wb_pc !== 32'd0) $display("FAIL rst_no_beat2 got %b %h exp 0 0", we_o2, debug_wb_pc); else pass_cnt++;
   endtask

   task automatic test_dual;
      logic [31:0] e_pc;
      total_cnt++; if (ready_o !== 1'b1) $display("FAIL dual_ready0 got %b exp 1", ready_o); else pass_cnt++;
      drive(1'b1, 1'b1, 1'b1, 32'hbfc00000, 32'hbfc00004, 1'b1, 1'b1, 5'd3, 5'd4, 32'h11, 32'h22);
      @(negedge clk);
      total_cnt++; if ({we_o1, waddr_o1, wdata_o1} !== {1'b1, 5'd3, 32'h11}) $display("FAIL dual_port1 got %b %0d %h exp 1 3 11", we_o1, waddr_o1, wdata_o1); else pass_cnt++;
      total_cnt++; if ({we_o2, waddr_o2, wdata_o2} !== {1'b1, 5'd4, 32'h22}) $display("FAIL dual_port2 got %b %0d %h exp 1 4 22", we_o2, waddr_o2, wdata_o2); else pass_cnt++;
      e_pc = TRACE ? 32'hbfc00000 : 32'd0;
      total_cnt++; if (debug_wb_pc !== e_pc || debug_wb_rf_wnum !== (TRACE ? 5'd3 : 5'd0)) $display("FAIL dual_tr1 got %h %0d exp %h", debug_wb_pc, debug_wb_rf_wnum, e_pc); else pass_cnt++;
      total_cnt++; if (ready_o !== !TRACE) $display("FAIL dual_ready1 got %b exp %b", ready_o, !TRACE); else pass_cnt++;
      valid_i = 1'b0;
      @(negedge clk);
      total_cnt++; if (we_o1 !== 1'b0 || we_o2 !== 1'b0) $display("FAIL dual_pulse got %b%b exp 00", we_o1, we_o2); else pass_cnt++;
      e_pc = TRACE ? 32'hbfc00004 : 32'd0;
      total_cnt++; if (debug_wb_pc !== e_pc || debug_wb_rf_wdata !== (TRACE ? 32'h22 : 32'h0)) $display("FAIL dual_tr2 got %h %h exp %h", debug_wb_pc, debug_wb_rf_wdata, e_pc); else pass_cnt++;
      total_cnt++; if (debug_wb_rf_wen !== (TRACE ? 4'hf : 4'h0)) $display("FAIL dual_tr2_wen got %h", debug_wb_rf_wen); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (debug_wb_pc !== 32'd0 || debug_wb_rf_wen !== 4'h0 || waddr_o2 !== 5'd4) $display("FAIL dual_idle got %h %h %0d exp 0 0 4", debug_wb_pc, debug_wb_rf_wen, waddr_o2); else pass_cnt++;
   endtask

   task automatic test_collapse;
      drive(1'b1, 1'b1, 1'b1, 32'h100, 32'h104, 1'b1, 1'b1, 5'd5, 5'd5, 32'haa, 32'hbb);
      @(negedge clk);
      total_cnt++; if (we_o1 !== 1'b0) $display("FAIL col_we1 got %b exp 0", we_o1); else pass_cnt++;
      total_cnt++; if ({we_o2, waddr_o2, wdata_o2} !== {1'b1, 5'd5, 32'hbb}) $display("FAIL col_port2 got %b %0d %h exp 1 5 bb", we_o2, waddr_o2, wdata_o2); else pass_cnt++;
      total_cnt++; if (debug_wb_rf_wen !== (TRACE ? 4'hf : 4'h0) || debug_wb_rf_wdata !== (TRACE ? 32'haa : 32'h0)) $display("FAIL col_tr1 got %h %h", debug_wb_rf_wen, debug_wb_rf_wdata); else pass_cnt++;
      valid_i = 1'b0;
      @(negedge clk);
      total_cnt++; if (debug_wb_rf_wen !== (TRACE ? 4'hf : 4'h0) || debug_wb_pc !== (TRACE ? 32'h104 : 32'h0)) $display("FAIL col_tr2 got %h %h", debug_wb_rf_wen, debug_wb_pc); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_zero_reg;
      drive(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0, 5'd0, 5'd0, 32'h5a, 32'h0);
      @(negedge clk);
      total_cnt++; if (we_o1 !== 1'b0 || we_o2 !== 1'b0) $display("FAIL zero_we got %b%b exp 00", we_o1, we_o2); else pass_cnt++;
      total_cnt++; if (debug_wb_rf_wen !== 4'h0 || debug_wb_pc !== (TRACE ? 32'h200 : 32'h0)) $display("FAIL zero_tr got %h %h", debug_wb_rf_wen, debug_wb_pc); else pass_cnt++;
      total_cnt++; if (ready_o !== 1'b1) $display("FAIL zero_ready got %b exp 1", ready_o); else pass_cnt++;
      valid_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_slot2_only;
      drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h700, 1'b0, 1'b1, 5'd0, 5'd7, 32'h0, 32'h77);
      @(negedge clk);
      total_cnt++; if ({we_o1, we_o2, waddr_o2} !== {1'b0, 1'b1, 5'd7}) $display("FAIL s2_we got %b%b %0d exp 01 7", we_o1, we_o2, waddr_o2); else pass_cnt++;
      total_cnt++; if (debug_wb_pc !== (TRACE ? 32'h700 : 32'h0) || debug_wb_rf_wnum !== (TRACE ? 5'd7 : 5'd0)) $display("FAIL s2_tr got %h %0d", debug_wb_pc, debug_wb_rf_wnum); else pass_cnt++;
      total_cnt++; if (ready_o !== 1'b1) $display("FAIL s2_ready got %b exp 1", ready_o); else pass_cnt++;
      drive(1'b1, 1'b0, 1'b0, 32'h800, 32'h804, 1'b1, 1'b1, 5'd9, 5'd10, 32'h1, 32'h2);
      @(negedge clk);
      total_cnt++; if (we_o1 !== 1'b0 || we_o2 !== 1'b0 || debug_wb_pc !== 32'd0 || debug_wb_rf_wen !== 4'h0) $display("FAIL empty_pair got %b%b %h %h", we_o1, we_o2, debug_wb_pc, debug_wb_rf_wen); else pass_cnt++;
      valid_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) begin
            total_cnt++; if ({we_o1, waddr_o1, wdata_o1, we_o2} !== {1'b1, 5'(i), 32'h1000 + 32'(i - 1), 1'b0}) $display("FAIL b2b_wr%0d got %b %0d %h %b", i, we_o1, waddr_o1, wdata_o1, we_o2); else pass_cnt++;
            total_cnt++; if (debug_wb_pc !== (TRACE ? 32'h300 + 32'(4 * (i - 1)) : 32'h0)) $display("FAIL b2b_tr%0d got %h", i, debug_wb_pc); else pass_cnt++;
         end
         if (i < 8) begin
            total_cnt++; if (ready_o !== 1'b1) $display("FAIL b2b_ready%0d got %b exp 1", i, ready_o); else pass_cnt++;
            drive(1'b1, 1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 1'b1, 1'b0, 5'(i + 1), 5'd0, 32'h1000 + 32'(i), 32'h0);
         end else begin
            valid_i = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_dual_stream;
      if (TRACE) begin
         drive(1'b1, 1'b1, 1'b1, 32'h400, 32'h404, 1'b1, 1'b1, 5'd8, 5'd9, 32'h500, 32'h600);
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total_cnt++; if ({we_o1, waddr_o1, we_o2, wdata_o2} !== {1'b1, 5'(8 + 2 * k), 1'b1, 32'h600 + 32'(k)}) $display("FAIL ds_wr%0d got %b %0d %b %h", k, we_o1, waddr_o1, we_o2, wdata_o2); else pass_cnt++;
            total_cnt++; if (ready_o !== 1'b0 || debug_wb_pc !== 32'h400 + 32'(8 * k)) $display("FAIL ds_b1_%0d got %b %h", k, ready_o, debug_wb_pc); else pass_cnt++;
            if (k < 3) drive(1'b1, 1'b1, 1'b1, 32'h400 + 32'(8 * (k + 1)), 32'h404 + 32'(8 * (k + 1)), 1'b1, 1'b1,
                             5'(10 + 2 * k), 5'(11 + 2 * k), 32'h501 + 32'(k), 32'h601 + 32'(k));
            else valid_i = 1'b0;
            @(negedge clk);
            total_cnt++; if (ready_o !== 1'b1 || we_o1 !== 1'b0 || debug_wb_rf_wnum !== 5'(9 + 2 * k)) $display("FAIL ds_b2_%0d got %b %b %0d", k, ready_o, we_o1, debug_wb_rf_wnum); else pass_cnt++;
         end
      end else begin
         for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
               total_cnt++; if ({we_o1, waddr_o1, we_o2, wdata_o2} !== {1'b1, 5'(6 + 2 * k), 1'b1, 32'h5ff + 32'(k)}) $display("FAIL ds_wr%0d got %b %0d %b %h", k, we_o1, waddr_o1, we_o2, wdata_o2); else pass_cnt++;
               total_cnt++; if (debug_wb_pc !== 32'd0 || debug_wb_rf_wen !== 4'h0 || debug_wb_rf_wnum !== 5'd0) $display("FAIL ds_dbg%0d got %h %h %0d", k, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum); else pass_cnt++;
            end
            if (k < 4) begin
               total_cnt++; if (ready_o !== 1'b1) $display("FAIL ds_ready%0d got %b exp 1", k, ready_o); else pass_cnt++;
               drive(1'b1, 1'b1, 1'b1, 32'h400 + 32'(8 * k), 32'h404 + 32'(8 * k), 1'b1, 1'b1,
                     5'(8 + 2 * k), 5'(9 + 2 * k), 32'h500 + 32'(k), 32'h600 + 32'(k));
            end else begin
               valid_i = 1'b0;
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
      test_reset();
      test_dual();
      test_collapse();
      test_zero_reg();
      test_slot2_only();
      test_back_to_back();
      test_dual_stream();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
